// File: rtl/signal_capture_pkg.sv
// Shared definitions for the multi-lane supersampling capture block.
//   DEF_RATE / DEF_WINDOW / DEF_LOCK_EDGES : default lane timing parameters
//   lock_state_t                           : per-lane lock FSM encoding
//   maj3()                                 : 3-tap majority vote
//   in_window()                            : true when an edge at phase p is within the jitter window
package signal_capture_pkg;

    localparam int DEF_RATE       = 12;
    localparam int DEF_WINDOW     = 2;
    localparam int DEF_LOCK_EDGES = 4;

    typedef enum logic {
        ST_HUNT   = 1'b0,
        ST_LOCKED = 1'b1
    } lock_state_t;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // The nominal edge lands at p == rate-1. Early edges fall in the top
    // 'window' phases, late ones wrap past zero into 0..window-1.
    function automatic logic in_window(input int p, input int rate, input int window);
        return (p >= rate - 1 - window) || (p <= window - 1);
    endfunction

endpackage

// File: rtl/signal_capture_array_if.sv
// Bus bundle for signal_capture_array.
//   ce, en, d, ack           : driven by the master (radio front-end side)
//   q, valid, locked, invalid: driven by the slave (capture block)
//   lane_strobe, lane_state  : per-lane observation signals (mid-bit strobe, lock FSM state)
// Handshake: valid is a one-cycle strobe with no backpressure; q is fresh in
// the cycle valid is high and holds its value until the next strobe.
interface signal_capture_array_if
    import signal_capture_pkg::*;
#(
    parameter int NUM_CHANNELS = 24
);
    logic                                ce;
    logic [NUM_CHANNELS-1:0]             en;
    logic [NUM_CHANNELS-1:0]             d;
    logic [NUM_CHANNELS-1:0]             ack;
    logic [NUM_CHANNELS-1:0]             q;
    logic                                valid;
    logic [NUM_CHANNELS-1:0]             locked;
    logic [NUM_CHANNELS-1:0]             invalid;
    logic [NUM_CHANNELS-1:0]             lane_strobe;
    lock_state_t [NUM_CHANNELS-1:0]      lane_state;

    modport master (
        output ce, en, d, ack,
        input  q, valid, locked, invalid, lane_strobe, lane_state
    );

    modport slave (
        input  ce, en, d, ack,
        output q, valid, locked, invalid, lane_strobe, lane_state
    );

endinterface

// File: rtl/signal_capture_array_lane.sv
// capture_lane: one oversampled serial lane.
//   clk, rst      : clock, synchronous active-high reset
//   ce            : sample enable, all state holds when low
//   d             : asynchronous serial input
//   ack           : clear for the sticky invalid flag
//   b_next        : lane bit as it will be after this cycle (majority sample or held)
//   sample_strobe : high on ce cycles at the mid-bit phase
//   locked        : lane has seen LOCK_EDGES consecutive in-window edges
//   invalid       : sticky, an out-of-window edge arrived while locked
//   state_dbg     : lock FSM state
module capture_lane
    import signal_capture_pkg::*;
#(
    parameter int RATE       = DEF_RATE,
    parameter int WINDOW     = DEF_WINDOW,
    parameter int LOCK_EDGES = DEF_LOCK_EDGES,
    parameter int CW         = $clog2(RATE)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce,
    input  logic        d,
    input  logic        ack,
    output logic        b_next,
    output logic        sample_strobe,
    output logic        locked,
    output logic        invalid,
    output lock_state_t state_dbg
);

    localparam logic [CW-1:0] P_LAST   = CW'(RATE - 1);
    localparam logic [CW-1:0] P_HALF   = CW'((RATE - 1) >> 1);
    localparam logic [3:0]    LOCK_MAX = 4'(LOCK_EDGES);

    logic          s0, s1, s2;
    logic [CW-1:0] p;
    logic          b;
    logic [3:0]    lock_cnt, cnt_nx;
    lock_state_t   state, state_nx;
    logic          edge_det;
    logic          win;

    assign edge_det      = s1 ^ s2;
    assign win           = in_window(int'(p), RATE, WINDOW);
    assign sample_strobe = ce & (p == P_HALF);
    // s2..s0 span three consecutive samples around mid-bit, so a single-cycle
    // glitch is outvoted.
    assign b_next        = sample_strobe ? maj3(s0, s1, s2) : b;
    assign locked        = (state == ST_LOCKED);
    assign state_dbg     = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            s0      <= 1'b0;
            s1      <= 1'b0;
            s2      <= 1'b0;
            p       <= '0;
            b       <= 1'b0;
            invalid <= 1'b0;
        end else if (ce) begin
            s0 <= d;
            s1 <= s0;
            s2 <= s1;
            // Every edge realigns the phase, in window or not.
            if (edge_det || (p == P_LAST)) begin
                p <= '0;
            end else begin
                p <= p + 1'b1;
            end
            b       <= b_next;
            // A new violation takes priority over a simultaneous ack.
            invalid <= (invalid & ~ack) | (locked & edge_det & ~win);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_HUNT;
            lock_cnt <= '0;
        end else if (ce) begin
            state    <= state_nx;
            lock_cnt <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = lock_cnt;
        if (edge_det) begin
            if (win) begin
                if (lock_cnt != LOCK_MAX) begin
                    cnt_nx = lock_cnt + 4'd1;
                end
                if (cnt_nx == LOCK_MAX) begin
                    state_nx = ST_LOCKED;
                end
            end else begin
                cnt_nx   = '0;
                state_nx = ST_HUNT;
            end
        end
    end

endmodule

// File: rtl/signal_capture_array.sv
// signal_capture_array: NUM_CHANNELS oversampled capture lanes presented as one word.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of signal_capture_array_if
//              ce/en/d/ack in; q/valid/locked/invalid out; lane_strobe/lane_state observation
// The word is registered on the REF_LANE mid-bit strobe. Other lanes contribute
// their most recent sampled bit, which may have been taken earlier in the bit.
module signal_capture_array
    import signal_capture_pkg::*;
#(
    parameter int NUM_CHANNELS = 24,
    parameter int RATE         = DEF_RATE,
    parameter int WINDOW       = DEF_WINDOW,
    parameter int LOCK_EDGES   = DEF_LOCK_EDGES,
    parameter int REF_LANE     = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    signal_capture_array_if.slave  bus
);

    logic [NUM_CHANNELS-1:0] b_next;
    logic [NUM_CHANNELS-1:0] strobe;
    logic [NUM_CHANNELS-1:0] locked_w;
    logic [NUM_CHANNELS-1:0] invalid_w;
    logic [NUM_CHANNELS-1:0] q_r;
    logic                    valid_r;
    logic                    word_ok;

    for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_lane
        capture_lane #(
            .RATE       (RATE),
            .WINDOW     (WINDOW),
            .LOCK_EDGES (LOCK_EDGES)
        ) u_lane (
            .clk           (clk),
            .rst           (rst),
            .ce            (bus.ce),
            .d             (bus.d[gi]),
            .ack           (bus.ack[gi]),
            .b_next        (b_next[gi]),
            .sample_strobe (strobe[gi]),
            .locked        (locked_w[gi]),
            .invalid       (invalid_w[gi]),
            .state_dbg     (bus.lane_state[gi])
        );
    end

    // Disabled lanes never block the word; with en all-zero the strobe alone decides.
    assign word_ok = &(locked_w | ~bus.en);

    always_ff @(posedge clk) begin
        if (rst) begin
            q_r     <= '0;
            valid_r <= 1'b0;
        end else begin
            valid_r <= strobe[REF_LANE] & word_ok;
            if (strobe[REF_LANE]) begin
                q_r <= b_next;
            end
        end
    end

    assign bus.q           = q_r;
    assign bus.valid       = valid_r;
    assign bus.locked      = locked_w;
    assign bus.invalid     = invalid_w;
    assign bus.lane_strobe = strobe;

endmodule

// File: tb/tb_signal_capture_array.sv
// Directed bench for signal_capture_array (4 lanes, RATE 12, WINDOW 2, LOCK_EDGES 4).
module tb_signal_capture_array;

    logic clk;
    logic rst;

    signal_capture_array_if #(.NUM_CHANNELS(4)) bus ();

    signal_capture_array #(
        .NUM_CHANNELS (4),
        .RATE         (12),
        .WINDOW       (2),
        .LOCK_EDGES   (4),
        .REF_LANE     (0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    int         checks = 0;
    int         errors = 0;
    int         cycle = 0;
    int         vcount = 0;
    int         last_vcyc = 0;
    int         prev_vcyc = 0;
    logic [3:0] last_q = 4'h0;
    logic       half = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // driver tasks: inputs change #1 after the edge, outputs observed there too
    task automatic cyc(input logic [3:0] dv, input logic [3:0] av, input logic cev);
        bus.d   = dv;
        bus.ack = av;
        bus.ce  = cev;
        @(posedge clk);
        #1;
        cycle++;
        if (bus.valid === 1'b1) begin
            vcount++;
            prev_vcyc = last_vcyc;
            last_vcyc = cycle;
            last_q    = bus.q;
        end
    endtask

    // one ce-counted sample period: 1 clk at full rate, 2 clks when half
    task automatic unit(input logic [3:0] dv, input logic [3:0] av);
        cyc(dv, av, 1'b1);
        if (half) cyc(dv, 4'h0, 1'b0);
    endtask

    task automatic run(input logic [3:0] dv, input int n);
        repeat (n) unit(dv, 4'h0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc(4'h0, 4'h0, 1'b1);
        cyc(4'h0, 4'h0, 1'b1);
        rst = 1'b0;
    endtask

    // From a fresh reset: 9 idle periods put the first edge at the nominal
    // phase, then six 12-period bits pat,0,pat,0,pat,0. Lock lands on the
    // 4th edge (start of bit 3); each bit from then on gives one valid.
    task automatic lock_up(input logic [3:0] pat, input logic [3:0] lmask, input string nm);
        logic [3:0] val;
        run(4'h0, 9);
        for (int bi = 0; bi < 6; bi++) begin
            val    = (bi % 2 == 0) ? pat : 4'h0;
            vcount = 0;
            run(val, 12);
            if (bi < 3) chk($sformatf("%s bit%0d no valid before lock", nm, bi), vcount, 0);
            if (bi == 2) chk($sformatf("%s locked after 3 edges", nm), bus.locked, 4'h0);
            if (bi == 3) chk($sformatf("%s locked after 4 edges", nm), bus.locked, lmask);
            if (bi >= 3) begin
                chk($sformatf("%s bit%0d one valid", nm, bi), vcount, 1);
                chk($sformatf("%s bit%0d q", nm, bi), last_q, val);
            end
        end
        chk($sformatf("%s valid spacing", nm), last_vcyc - prev_vcyc, half ? 24 : 12);
    endtask

    initial begin
        rst     = 1'b1;
        bus.ce  = 1'b0;
        bus.en  = 4'hF;
        bus.d   = 4'h0;
        bus.ack = 4'h0;

        // reset state
        do_reset();
        chk("reset q", bus.q, 4'h0);
        chk("reset valid", bus.valid, 1'b0);
        chk("reset locked", bus.locked, 4'h0);
        chk("reset invalid", bus.invalid, 4'h0);

        // clean alternating pattern, full rate
        lock_up(4'hF, 4'hF, "full");

        // lane 2 jitter: edge 10 then 14 clks apart, lock held
        vcount = 0;
        run(4'hF, 10);
        run(4'b1011, 2);
        chk("jit bit q", last_q, 4'hF);
        vcount = 0;
        run(4'h0, 12);
        chk("jit early lane q", last_q, 4'h0);
        chk("jit early lane valid", vcount, 1);
        vcount = 0;
        run(4'hF, 9);
        chk("jit late edge locked", bus.locked, 4'hF);
        chk("jit late edge invalid", bus.invalid, 4'h0);
        chk("jit late edge valid", vcount, 1);
        // lane 2 edge 9 clks apart: out of window
        run(4'b1011, 3);
        chk("spacing9 locked", bus.locked, 4'b1011);
        chk("spacing9 invalid", bus.invalid, 4'b0100);
        vcount = 0;
        run(4'h0, 12);
        chk("spacing9 valid suppressed", vcount, 0);

        // re-lock lane 2: first edge after the violation is out of window, then 4 clean
        for (int c = 0; c < 5; c++) begin
            vcount = 0;
            run((c % 2 == 0) ? 4'hF : 4'h0, 12);
            if (c == 3) begin
                chk("relock lane2 not yet", bus.locked, 4'b1011);
                chk("relock lane2 no valid", vcount, 0);
            end
        end
        chk("relock lane2 locked", bus.locked, 4'hF);
        chk("relock invalid sticky", bus.invalid, 4'b0100);
        chk("relock valid", vcount, 1);
        chk("relock q", last_q, 4'hF);

        // ack against a simultaneous violation, then a plain ack
        vcount = 0;
        run(4'b0100, 9);
        chk("held lane bit in word valid", vcount, 1);
        chk("held lane bit in word q", last_q, 4'b0100);
        cyc(4'h0, 4'h0, 1'b1);
        cyc(4'h0, 4'h0, 1'b1);
        cyc(4'h0, 4'b0100, 1'b1);
        chk("ack vs set invalid", bus.invalid, 4'b0100);
        chk("ack vs set locked", bus.locked, 4'b1011);
        cyc(4'h0, 4'b0100, 1'b1);
        chk("ack clears invalid", bus.invalid, 4'h0);
        run(4'h0, 11);

        // one-clk glitch on lane 1 at the sample point, lane 2 masked off
        bus.en = 4'b1011;
        vcount = 0;
        run(4'hF, 6);
        cyc(4'b1101, 4'h0, 1'b1);
        run(4'hF, 5);
        chk("glitch valid", vcount, 1);
        chk("glitch rejected q", last_q, 4'hF);
        chk("glitch locked", bus.locked, 4'b1001);
        chk("glitch invalid", bus.invalid, 4'b0010);

        // en all-zero: valid follows the reference strobe alone
        bus.en = 4'h0;
        do_reset();
        vcount = 0;
        run(4'h0, 12);
        chk("en0 strobe valid", vcount, 1);
        chk("en0 locked", bus.locked, 4'h0);

        // en on lane 0 only, lanes 1-3 constant
        bus.en = 4'b0001;
        lock_up(4'b0001, 4'b0001, "en1");

        // half-rate ce, same sequence in ce periods
        bus.en = 4'hF;
        half   = 1'b1;
        do_reset();
        lock_up(4'hF, 4'hF, "half");

        // reset mid-stream then re-lock
        run(4'h0, 5);
        rst = 1'b1;
        cyc(4'h0, 4'h0, 1'b1);
        rst = 1'b0;
        chk("midrst q", bus.q, 4'h0);
        chk("midrst valid", bus.valid, 1'b0);
        chk("midrst locked", bus.locked, 4'h0);
        chk("midrst invalid", bus.invalid, 4'h0);
        lock_up(4'hF, 4'hF, "relock");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
